clock_divider: RTL and testbench

//  Derives a slow, free-running square-wave clock from the system clock by integer division.

---
 rtl/clock_divider.sv | 61 ++++++
 tb/tb_clock_divider.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/clock_divider.sv
// Integer clock divider producing a registered square wave slow_clk from clk.
// Optional one-cycle rising-edge strobe slow_tick when CLOCK_DIVIDER_TICK_EN is defined.
module clock_divider #(
  parameter int BASE_FREQ   = 50_000_000,
  parameter int TARGET_FREQ = 50
) (
  input  logic clk,
  input  logic rst,
  output logic slow_clk
`ifdef CLOCK_DIVIDER_TICK_EN
  ,
  output logic slow_tick
`endif
);

  // Guard the division so a zero target still elaborates far enough to report the error.
  localparam int DIVISOR    = (TARGET_FREQ == 0) ? 0 : BASE_FREQ / TARGET_FREQ;
  localparam int LOW_CYCLES = DIVISOR / 2;
  localparam int CNT_W      = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] CNT_LOW  = CNT_W'(LOW_CYCLES);

  generate
    if (TARGET_FREQ == 0) begin : g_bad_target
      $error("clock_divider: TARGET_FREQ must be non-zero");
    end
    if (DIVISOR < 2) begin : g_bad_divisor
      $error("clock_divider: BASE_FREQ/TARGET_FREQ must be at least 2");
    end
  endgenerate

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      slow_clk <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      slow_clk <= (cnt_next >= CNT_LOW);
    end
  end

`ifdef CLOCK_DIVIDER_TICK_EN
  // cnt_next hits CNT_LOW exactly once per period, on the edge where slow_clk rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slow_tick <= 1'b0;
    end else begin
      slow_tick <= (cnt_next == CNT_LOW);
    end
  end
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench for clock_divider: DIVISOR=4 vector table plus hand sequences,
// and a DIVISOR=5 instance for the odd-ratio duty cycle.
module tb_clock_divider;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst5 = 1'b1;
  logic slow_clk;
  logic slow_clk5;
`ifdef CLOCK_DIVIDER_TICK_EN
  logic slow_tick;
  logic slow_tick5;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  clock_divider #(.BASE_FREQ(8), .TARGET_FREQ(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .slow_clk (slow_clk)
`ifdef CLOCK_DIVIDER_TICK_EN
    ,
    .slow_tick(slow_tick)
`endif
  );

  clock_divider #(.BASE_FREQ(10), .TARGET_FREQ(2)) dut5 (
    .clk      (clk),
    .rst      (rst5),
    .slow_clk (slow_clk5)
`ifdef CLOCK_DIVIDER_TICK_EN
    ,
    .slow_tick(slow_tick5)
`endif
  );

  typedef struct {
    logic rst;
    logic exp_slow;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    logic prev_exp;
    logic exp_v;
    int   rises;
    int   ticks;

    // Rows: rst level applied before the next posedge, slow_clk expected after it.
    vecs.push_back('{1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1});
    vecs.push_back('{1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0});

    @(posedge clk);
    #1;
    check("reset_state", 0, slow_clk, 1'b0);
`ifdef CLOCK_DIVIDER_TICK_EN
    check("reset_tick", 0, slow_tick, 1'b0);
`endif

    prev_exp = 1'b0;
    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      @(posedge clk);
      #1;
      check("table_slow", i, slow_clk, vecs[i].exp_slow);
`ifdef CLOCK_DIVIDER_TICK_EN
      check("table_tick", i, slow_tick, vecs[i].exp_slow & ~prev_exp);
`endif
      prev_exp = vecs[i].exp_slow;
      $display("vec %0d: rst=%b slow_clk=%b exp=%b", i, vecs[i].rst, slow_clk, vecs[i].exp_slow);
    end

    // Restart cleanly and get into the high phase.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_high_setup", 0, slow_clk, 1'b1);

    // Asynchronous assertion between edges must clear slow_clk at once.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_drop", 0, slow_clk, 1'b0);
    for (int h = 0; h < 3; h++) begin
      @(posedge clk);
      #1;
      check("hold_in_reset", h, slow_clk, 1'b0);
    end
    rst = 1'b0;

    // First rise at the 2nd posedge after release, then 100+ periods of 4 with no drift.
    rises = 0;
    ticks = 0;
    prev_exp = 1'b0;
    for (int k = 1; k <= 408; k++) begin
      @(posedge clk);
      #1;
      exp_v = ((k % 4) >= 2);
      check("steady_slow", k, slow_clk, exp_v);
      if (slow_clk && !prev_exp) rises++;
      prev_exp = slow_clk;
`ifdef CLOCK_DIVIDER_TICK_EN
      check("steady_tick", k, slow_tick, (k % 4) == 2);
      if (slow_tick) ticks++;
`endif
    end
    check_int("rise_count", rises, 102);
`ifdef CLOCK_DIVIDER_TICK_EN
    check_int("tick_count", ticks, rises);
`endif
    $display("steady: rises=%0d ticks=%0d", rises, ticks);

    // Odd ratio: low 2, high 3, period 5.
    rst5 = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      #1;
      check("odd_slow", k, slow_clk5, (k % 5) >= 2);
`ifdef CLOCK_DIVIDER_TICK_EN
      check("odd_tick", k, slow_tick5, (k % 5) == 2);
`endif
    end
    $display("odd ratio: 25 cycles checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
